// File: rtl/prev_ram_ctrl_pkg.sv
// Purpose : shared types and defaults for the prev-pointer RAM controller.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package prev_ram_ctrl_pkg;

    // Controller phase: sweep-initialise the RAM, then serve requesters.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_AW    = 3;
    localparam int DEF_DW    = 3;
    localparam int DEF_NREQ  = 2;

    // Values loaded into the table by the init sweep.
    localparam int INIT_ZERO     = 0;   // every entry = 0
    localparam int INIT_IDENTITY = 1;   // entry k = k

endpackage

// File: rtl/prev_ram_ctrl_rr_arbiter.sv
// Purpose : N-way round-robin arbiter, one-hot grant, pointer moves on grant only.
// Latency : grant is combinational from req/en; pointer updates at the grant edge.
// Backpr. : a requester not granted simply keeps requesting; en=0 forces no grant.
//
// Ports: clock/reset (sync, active-high), en (arbitration allowed),
//        req (request vector), grant (one-hot or zero).
module rr_arbiter
    import prev_ram_ctrl_pkg::*;
#(
    parameter int N = DEF_NREQ
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last;    // index of the most recent grant
    logic [PW-1:0] gidx;    // index granted this cycle (valid when |grant)
    logic [PW-1:0] cand;

    // Scan starts one past the last winner and wraps, so the last winner is
    // considered only after everyone else.
    always_comb begin
        grant = '0;
        gidx  = last;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = PW'((int'(last) + i) % N);
            if (en && req[cand] && (grant == '0)) begin
                grant[cand] = 1'b1;
                gidx        = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last <= '0;
        end else if (|grant) begin
            last <= gidx;
        end
    end

endmodule

// File: rtl/prev_ram_ctrl.sv
// Purpose : init sweep + round-robin access to the 1R1W "prev" pointer RAM macro.
// Latency : write lands at the grant edge; read response pulses 1 cycle after grant.
// Backpr. : ready is withheld during init and from losers; responses cannot be stalled.
//
// Ports: clock, reset (sync, active-high); per-requester rd_valid/rd_addr/rd_ready,
//        rsp_valid + shared rsp_data; wr_valid/wr_addr/wr_data/wr_ready; init_done;
//        mem_w_* / mem_r_* / mem_r_data to the RAM macro W0/R0 ports.
module prev_ram_ctrl
    import prev_ram_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int NREQ      = DEF_NREQ,
    parameter int INIT_MODE = INIT_IDENTITY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   rd_valid,
    input  logic [NREQ*AW-1:0] rd_addr,
    output logic [NREQ-1:0]   rd_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
    input  logic [NREQ-1:0]   wr_valid,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]   wr_ready,
    output logic              init_done,
    output logic              mem_w_en,
    output logic [AW-1:0]     mem_w_addr,
    output logic [DW-1:0]     mem_w_data,
    output logic              mem_r_en,
    output logic [AW-1:0]     mem_r_addr,
    input  logic [DW-1:0]     mem_r_data
);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [NREQ-1:0] rsp_q;
    logic            run;

    // Gating with reset keeps every strobe quiet in the reset cycle itself,
    // even when reset lands while the controller is in RUN.
    assign run = (state == ST_RUN) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
            rsp_q <= '0;
        end else begin
            rsp_q <= rd_ready;
            if (state == ST_INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state <= ST_RUN;
                end
            end
        end
    end

    rr_arbiter #(.N(NREQ)) u_rd_arb (
        .clock (clock),
        .reset (reset),
        .en    (run),
        .req   (rd_valid),
        .grant (rd_ready)
    );

    rr_arbiter #(.N(NREQ)) u_wr_arb (
        .clock (clock),
        .reset (reset),
        .en    (run),
        .req   (wr_valid),
        .grant (wr_ready)
    );

    always_comb begin
        mem_w_en   = 1'b0;
        mem_w_addr = '0;
        mem_w_data = '0;
        mem_r_en   = 1'b0;
        mem_r_addr = '0;
        if (!reset && (state == ST_INIT)) begin
            mem_w_en   = 1'b1;
            mem_w_addr = cnt;
            mem_w_data = (INIT_MODE == INIT_IDENTITY) ? DW'(cnt) : '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (wr_ready[i]) begin
                    mem_w_en   = 1'b1;
                    mem_w_addr = wr_addr[i*AW +: AW];
                    mem_w_data = wr_data[i*DW +: DW];
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rd_ready[i]) begin
                mem_r_en   = 1'b1;
                mem_r_addr = rd_addr[i*AW +: AW];
            end
        end
    end

    // The macro holds R0_data until the next read, so it is only sampled in
    // the response cycle; outside it the bus is forced to zero. Reset drops
    // a response that is already in flight.
    assign rsp_valid = reset ? '0 : rsp_q;
    assign rsp_data  = (|rsp_valid) ? mem_r_data : '0;
    assign init_done = run;

endmodule

// File: tb/tb_prev_ram_ctrl.sv
module tb_prev_ram_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] rd_valid, rd_ready, rsp_valid, wr_valid, wr_ready;
    logic [5:0] rd_addr, wr_addr, wr_data;
    logic [2:0] rsp_data, mem_w_addr, mem_w_data, mem_r_addr;
    logic [2:0] mem_r_data = 3'd0;
    logic       init_done, mem_w_en, mem_r_en;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    prev_ram_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .init_done  (init_done),
        .mem_w_en   (mem_w_en),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_r_en   (mem_r_en),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data)
    );

    // Behavioural 8x3 1R1W macro: registered read, write-first on collision.
    logic [2:0] ram [8];
    always @(posedge clock) begin
        if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= (mem_w_en && mem_w_addr == mem_r_addr) ? mem_w_data : ram[mem_r_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are changed right after an edge; outputs are checked 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g [4];
        logic [2:0] exp_d [4];
        reset = 1'b1;
        rd_valid = 2'b11; rd_addr = {3'd6, 3'd2};
        wr_valid = 2'b11; wr_addr = {3'd1, 3'd1}; wr_data = {3'd0, 3'd0};
        #1; tick(); tick();
        // reset state, with valids pending
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_data",  rsp_data,  3'd0);
        check("rst_rd_ready",  rd_ready,  2'b00);
        check("rst_wr_ready",  wr_ready,  2'b00);
        check("rst_init_done", init_done, 1'b0);
        check("rst_mem_w_en",  mem_w_en,  1'b0);
        check("rst_mem_r_en",  mem_r_en,  1'b0);

        // init sweep: identity values, no grants
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("init%0d_w_en", k),   mem_w_en,   1'b1);
            check($sformatf("init%0d_w_addr", k), mem_w_addr, k);
            check($sformatf("init%0d_w_data", k), mem_w_data, k);
            check($sformatf("init%0d_rd_rdy", k), rd_ready,   2'b00);
            check($sformatf("init%0d_wr_rdy", k), wr_ready,   2'b00);
            check($sformatf("init%0d_done", k),   init_done,  1'b0);
            if (k == 7) begin rd_valid = 2'b00; wr_valid = 2'b00; end
            tick();
        end
        #1;
        check("init_done_up", init_done, 1'b1);
        check("run_idle_w_en", mem_w_en, 1'b0);

        // single read, req0 addr 5
        rd_valid = 2'b01; rd_addr = {3'd0, 3'd5};
        #1;
        check("rd5_ready", rd_ready, 2'b01);
        check("rd5_r_en", mem_r_en, 1'b1);
        check("rd5_r_addr", mem_r_addr, 3'd5);
        tick(); rd_valid = 2'b00; #1;
        check("rd5_rsp_valid", rsp_valid, 2'b01);
        check("rd5_rsp_data", rsp_data, 3'd5);
        check("rd5_idle_r_en", mem_r_en, 1'b0);
        tick(); #1;
        check("rd5_rsp_gone", rsp_valid, 2'b00);
        check("rd5_data_zero", rsp_data, 3'd0);

        // single read, req1 addr 1 (leaves read pointer at 1)
        rd_valid = 2'b10; rd_addr = {3'd1, 3'd0};
        #1;
        check("rd1_ready", rd_ready, 2'b10);
        tick(); rd_valid = 2'b00; #1;
        check("rd1_rsp_valid", rsp_valid, 2'b10);
        check("rd1_rsp_data", rsp_data, 3'd1);

        // both requesters hold for 4 cycles: grants 0,1,0,1
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        exp_d[0] = 3'd2;  exp_d[1] = 3'd6;  exp_d[2] = 3'd2;  exp_d[3] = 3'd6;
        tick();
        rd_valid = 2'b11; rd_addr = {3'd6, 3'd2};
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr%0d_grant", k), rd_ready, exp_g[k]);
            check($sformatf("rr%0d_r_addr", k), mem_r_addr, exp_d[k]);
            if (k > 0) begin
                check($sformatf("rr%0d_rsp_valid", k), rsp_valid, exp_g[k-1]);
                check($sformatf("rr%0d_rsp_data", k), rsp_data, exp_d[k-1]);
            end
            tick();
        end
        rd_valid = 2'b00; #1;
        check("rr_last_rsp_valid", rsp_valid, 2'b10);
        check("rr_last_rsp_data", rsp_data, 3'd6);

        // same-cycle write (req1: addr3=7) and read (req0: addr3)
        rd_valid = 2'b01; rd_addr = {3'd0, 3'd3};
        wr_valid = 2'b10; wr_addr = {3'd3, 3'd0}; wr_data = {3'd7, 3'd0};
        #1;
        check("wf_wr_ready", wr_ready, 2'b10);
        check("wf_rd_ready", rd_ready, 2'b01);
        check("wf_w_addr", mem_w_addr, 3'd3);
        check("wf_w_data", mem_w_data, 3'd7);
        tick();
        rd_valid = 2'b00; wr_data = {3'd1, 3'd0};
        #1;
        check("wf_rsp_valid", rsp_valid, 2'b01);
        check("wf_rsp_data", rsp_data, 3'd7);
        check("wf2_w_data", mem_w_data, 3'd1);
        tick(); wr_valid = 2'b00;
        rd_valid = 2'b01; rd_addr = {3'd0, 3'd3};
        tick(); rd_valid = 2'b00; #1;
        check("wf_readback", rsp_data, 3'd1);

        // write contention: last write winner was req1, so req0 first, then req1
        wr_valid = 2'b11; wr_addr = {3'd2, 3'd2}; wr_data = {3'd5, 3'd5};
        #1;
        check("wrr0_grant", wr_ready, 2'b01);
        tick(); #1;
        check("wrr1_grant", wr_ready, 2'b10);
        tick(); wr_valid = 2'b00;

        // reset mid-stream: read granted in T, reset in T+1
        rd_valid = 2'b01; rd_addr = {3'd0, 3'd4};
        #1;
        check("mr_grant", rd_ready, 2'b01);
        tick(); rd_valid = 2'b00; reset = 1'b1; #1;
        check("mr_rsp_dropped", rsp_valid, 2'b00);
        check("mr_rsp_data", rsp_data, 3'd0);
        tick(); #1;
        check("mr_rsp_still0", rsp_valid, 2'b00);
        check("mr_done_low", init_done, 1'b0);
        reset = 1'b0; #1;
        check("mr_restart_addr", mem_w_addr, 3'd0);
        check("mr_restart_en", mem_w_en, 1'b1);
        for (int k = 0; k < 8; k++) tick();
        #1;
        check("mr_init_done", init_done, 1'b1);

        // read back all entries: identity restored (entry 3 and 2 overwritten earlier)
        rd_valid = 2'b01;
        for (int k = 0; k <= 8; k++) begin
            rd_addr = {3'd0, 3'(k)};
            if (k == 8) rd_valid = 2'b00;
            #1;
            if (k > 0) begin
                check($sformatf("id%0d_rsp_valid", k-1), rsp_valid, 2'b01);
                check($sformatf("id%0d_rsp_data", k-1), rsp_data, k-1);
            end
            tick();
        end
        #1;
        check("end_rsp_idle", rsp_valid, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
